// File: rtl/filter_stream_pipe_if.sv
// Valid/ready pixel stream link: one beat per transfer, SOF marks the first pixel of a frame.
interface filter_stream_pipe_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              sof;

    modport master (output valid, data, sof, input ready);
    modport slave  (input valid, data, sof, output ready);
endinterface

// File: rtl/filter_stream_pipe.sv
// Two-stage pipelined per-pixel filter (bypass / brightness / invert / grayscale) with
// mode and brightness offset captured on the SOF beat of each frame.
module filter_stream_pipe #(
    parameter int CH_W     = 8,
    parameter int NUM_CH   = 4,
    parameter int ALPHA_EN = 1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    filter_stream_pipe_if.slave  in_s,
    filter_stream_pipe_if.master out_m,
    input  logic [1:0]           filter_mode,
    input  logic [CH_W-1:0]      brightness_coeff,
    output logic [1:0]           active_mode,
    output logic                 mode_pending
);
    localparam int DATA_W  = NUM_CH * CH_W;
    localparam int SUM_W   = CH_W + 2;
    localparam int NUM_COL = NUM_CH - ALPHA_EN;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_BRIGHT = 2'b01,
        MODE_INVERT = 2'b10,
        MODE_GRAY   = 2'b11
    } mode_e;

    mode_e                            active_q;
    logic [CH_W-1:0]                  coeff_q;

    logic                             s1_valid, s1_sof;
    mode_e                            s1_mode;
    logic [DATA_W-1:0]                s1_data;
    logic [NUM_COL-1:0][SUM_W-1:0]    s1_bsum;
    logic [SUM_W-1:0]                 s1_gsum;

    logic                             s2_valid, s2_sof;
    logic [DATA_W-1:0]                s2_data;

    logic                             s1_load, s2_load, in_accept;
    mode_e                            beat_mode;
    logic [CH_W-1:0]                  beat_coeff;
    logic [NUM_COL-1:0][SUM_W-1:0]    bsum_d;
    logic [SUM_W-1:0]                 gsum_d;
    logic [DATA_W-1:0]                result;
    logic [CH_W-1:0]                  gray;

    assign s2_load   = !s2_valid || out_m.ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_s.ready = s1_load;
    assign in_accept = in_s.valid && s1_load;

    assign out_m.valid = s2_valid;
    assign out_m.data  = s2_data;
    assign out_m.sof   = s2_sof;

    assign active_mode  = active_q;
    assign mode_pending = (filter_mode != active_q);

    // An SOF beat is filtered with the values it is latching, not the previous frame's.
    assign beat_mode  = in_s.sof ? mode_e'(filter_mode) : active_q;
    assign beat_coeff = in_s.sof ? brightness_coeff : coeff_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        bsum_d = '0;
        for (int ch = 0; ch < NUM_COL; ch++) begin
            bsum_d[ch] = SUM_W'(in_s.data[ch*CH_W +: CH_W])
                       + {{2{beat_coeff[CH_W-1]}}, beat_coeff};
        end
    end

    generate
        if (NUM_COL >= 3) begin : g_gray
            assign gsum_d = SUM_W'(in_s.data[0 +: CH_W])
                          + SUM_W'({in_s.data[CH_W +: CH_W], 1'b0})
                          + SUM_W'(in_s.data[2*CH_W +: CH_W]);
        end else begin : g_no_gray
            assign gsum_d = '0;
        end
    endgenerate

    assign gray = CH_W'(s1_gsum >> 2);

    always_comb begin
        result = s1_data;
        for (int ch = 0; ch < NUM_COL; ch++) begin
            unique case (s1_mode)
                MODE_BYPASS: result[ch*CH_W +: CH_W] = s1_data[ch*CH_W +: CH_W];
                MODE_BRIGHT: begin
                    // Sum range fits SUM_W signed: sign bit means below zero, bit CH_W means overflow.
                    if (s1_bsum[ch][SUM_W-1])
                        result[ch*CH_W +: CH_W] = '0;
                    else if (s1_bsum[ch][CH_W])
                        result[ch*CH_W +: CH_W] = '1;
                    else
                        result[ch*CH_W +: CH_W] = s1_bsum[ch][CH_W-1:0];
                end
                MODE_INVERT: result[ch*CH_W +: CH_W] = ~s1_data[ch*CH_W +: CH_W];
                MODE_GRAY: begin
                    if (NUM_COL >= 3 && ch < 3)
                        result[ch*CH_W +: CH_W] = gray;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            active_q <= MODE_BYPASS;
            coeff_q  <= '0;
        end else if (in_accept && in_s.sof) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            active_q <= mode_e'(filter_mode);
            coeff_q  <= brightness_coeff;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_mode  <= MODE_BYPASS;
            s1_data  <= '0;
            s1_bsum  <= '0;
            s1_gsum  <= '0;
        end else if (s1_load) begin
            s1_valid <= in_s.valid;
            if (in_s.valid) begin
                s1_sof  <= in_s.sof;
                s1_mode <= beat_mode;
                s1_data <= in_s.data;
                s1_bsum <= bsum_d;
                s1_gsum <= gsum_d;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s2_valid <= 1'b0;
            s2_sof   <= 1'b0;
            s2_data  <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sof  <= s1_sof;
                s2_data <= result;
            end
        end
    end
endmodule

// File: tb/tb_filter_stream_pipe.sv
// Self-checking bench for filter_stream_pipe: vector table plus scoreboarded corner-case sequences.
module tb_filter_stream_pipe;
    logic       clk = 1'b0;
    logic       n_rst;
    logic [1:0] filter_mode;
    logic [7:0] brightness_coeff;
    logic [1:0] active_mode;
    logic       mode_pending;

    filter_stream_pipe_if #(.DATA_W(32)) in_if ();
    filter_stream_pipe_if #(.DATA_W(32)) out_if ();

    filter_stream_pipe #(.CH_W(8), .NUM_CH(4), .ALPHA_EN(1)) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .in_s             (in_if),
        .out_m            (out_if),
        .filter_mode      (filter_mode),
        .brightness_coeff (brightness_coeff),
        .active_mode      (active_mode),
        .mode_pending     (mode_pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        sof;
    } beat_t;

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  coeff;
        logic        sof;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    beat_t       exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          n_out = 0;
    logic [1:0]  m_mode;
    logic [7:0]  m_coeff;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference filter, written from the arithmetic definition with plain integers.
    function automatic logic [31:0] model(input logic [31:0] px, input logic [1:0] m, input logic [7:0] k);
        logic [31:0] r;
        int g, v, c;
        r = px;
        g = (int'(px[7:0]) + 2 * int'(px[15:8]) + int'(px[23:16])) / 4;
        for (int i = 0; i < 3; i++) begin
            c = int'(px[i*8 +: 8]);
            case (m)
                2'b00:   v = c;
                2'b01: begin
                    v = c + int'($signed(k));
                    if (v < 0) v = 0;
                    if (v > 255) v = 255;
                end
                2'b10:   v = 255 - c;
                default: v = g;
            endcase
            r[i*8 +: 8] = v[7:0];
        end
        return r;
    endfunction

    // Scoreboard side: pop on every output transfer, and watch hold-stability during stalls.
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_sof;
    always @(negedge clk) begin
        beat_t e;
        if (!n_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {31'b0, out_if.valid}, 32'd1);
                check("stall_data", out_if.data, prev_data);
                check("stall_sof", {31'b0, out_if.sof}, {31'b0, prev_sof});
            end
            if (out_if.valid && out_if.ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_beat", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_if.data, e.data);
                    check("out_sof", {31'b0, out_if.sof}, {31'b0, e.sof});
                    n_out++;
                end
            end
            prev_stall = out_if.valid && !out_if.ready;
            prev_data  = out_if.data;
            prev_sof   = out_if.sof;
        end
    end

    // Present one beat from posedge+1, wait (bounded) for acceptance, record the expectation.
    task automatic send(input logic [31:0] d, input logic sof, input logic [31:0] exp);
        int    waited;
        beat_t b;
        waited = 0;
        in_if.valid = 1'b1;
        in_if.data  = d;
        in_if.sof   = sof;
        @(negedge clk);
        while (!in_if.ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!in_if.ready) check("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        if (sof) begin
            m_mode  = filter_mode;
            m_coeff = brightness_coeff;
        end
        b.data = exp;
        b.sof  = sof;
        exp_q.push_back(b);
        #1 in_if.valid = 1'b0;
    endtask

    task automatic send_m(input logic [31:0] d, input logic sof);
        send(d, sof, sof ? model(d, filter_mode, brightness_coeff) : model(d, m_mode, m_coeff));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            t++;
            @(negedge clk);
        end
        check("drain_left", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    vec_t vecs[12];
    int   t_first, t_last, out_before;

    initial begin
        vecs[0]  = '{2'b00, 8'h00, 1'b1, 32'h1122_3344, 32'h1122_3344};
        vecs[1]  = '{2'b01, 8'h20, 1'b1, 32'h80F0_1040, 32'h80FF_3060};
        vecs[2]  = '{2'b01, 8'hE0, 1'b1, 32'h80F0_1040, 32'h80D0_0020};
        vecs[3]  = '{2'b11, 8'h00, 1'b1, 32'hFF40_8020, 32'hFF58_5858};
        vecs[4]  = '{2'b10, 8'h00, 1'b1, 32'h00FF_0F00, 32'h0000_F0FF};
        vecs[5]  = '{2'b01, 8'h7F, 1'b1, 32'h1200_0180, 32'h127F_80FF};
        vecs[6]  = '{2'b01, 8'h80, 1'b0, 32'h00FF_8081, 32'h00FF_FFFF};
        vecs[7]  = '{2'b01, 8'h80, 1'b1, 32'hAA7F_8081, 32'hAA00_0001};
        vecs[8]  = '{2'b11, 8'h00, 1'b1, 32'h00FF_FFFF, 32'h00FF_FFFF};
        vecs[9]  = '{2'b11, 8'h00, 1'b0, 32'h4003_0201, 32'h4002_0202};
        vecs[10] = '{2'b00, 8'h00, 1'b0, 32'h0102_0304, 32'h0103_0303};
        vecs[11] = '{2'b00, 8'h00, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};

        n_rst = 1'b0;
        in_if.valid = 1'b0;
        in_if.data  = '0;
        in_if.sof   = 1'b0;
        out_if.ready = 1'b1;
        filter_mode = 2'b00;
        brightness_coeff = 8'h00;
        m_mode  = 2'b00;
        m_coeff = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'b0, out_if.valid}, 32'd0);
        check("rst_out_data", out_if.data, 32'd0);
        check("rst_out_sof", {31'b0, out_if.sof}, 32'd0);
        check("rst_active_mode", {30'b0, active_mode}, 32'd0);
        check("rst_in_ready", {31'b0, in_if.ready}, 32'd1);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Latency: accepted on edge k, S1 after k, out_valid after k+1
        send(32'h1122_3344, 1'b1, 32'h1122_3344);
        @(negedge clk);
        check("lat_cycle1_valid", {31'b0, out_if.valid}, 32'd0);
        @(negedge clk);
        check("lat_cycle2_valid", {31'b0, out_if.valid}, 32'd1);
        @(posedge clk);
        #1;
        drain();

        // Table vectors streamed back to back
        for (int i = 0; i < 12; i++) begin
            filter_mode      = vecs[i].mode;
            brightness_coeff = vecs[i].coeff;
            send(vecs[i].data, vecs[i].sof, vecs[i].exp);
            if (i == 0) t_first = cyc;
            if (i == 11) t_last = cyc;
        end
        check("throughput_cycles", t_last - t_first, 32'd11);
        drain();

        // Mid-frame mode change takes effect only at the next SOF
        filter_mode = 2'b00;
        brightness_coeff = 8'h00;
        send_m(32'h0102_0304, 1'b1);
        filter_mode = 2'b10;
        #1;
        check("pending_set", {31'b0, mode_pending}, 32'd1);
        check("active_held", {30'b0, active_mode}, 32'd0);
        send(32'h55AA_55AA, 1'b0, 32'h55AA_55AA);
        send(32'h00FF_0F00, 1'b1, 32'h0000_F0FF);
        check("active_new", {30'b0, active_mode}, 32'd2);
        check("pending_clear", {31'b0, mode_pending}, 32'd0);
        drain();

        // Output stall: pipe fills after two beats, a stalled SOF is not latched early
        out_before = n_out;
        filter_mode = 2'b01;
        brightness_coeff = 8'h10;
        out_if.ready = 1'b0;
        send(32'h0102_0304, 1'b1, 32'h0112_1314);
        send(32'h0506_07F8, 1'b0, 32'h0516_17FF);
        in_if.valid = 1'b1;
        in_if.data  = 32'h0930_2010;
        in_if.sof   = 1'b1;
        filter_mode = 2'b11;
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", {31'b0, in_if.ready}, 32'd0);
            check("stall_active_mode", {30'b0, active_mode}, 32'd1);
        end
        @(posedge clk);
        #1 out_if.ready = 1'b1;
        send(32'h0930_2010, 1'b1, 32'h0920_2020);
        send_m(32'h0A04_0404, 1'b0);
        drain();
        check("stall_beat_count", n_out - out_before, 32'd4);

        // Asynchronous reset with both stages full
        filter_mode = 2'b10;
        brightness_coeff = 8'h00;
        out_if.ready = 1'b0;
        send_m(32'h1111_1111, 1'b1);
        send_m(32'h2222_2222, 1'b0);
        @(negedge clk);
        check("prerst_valid", {31'b0, out_if.valid}, 32'd1);
        #2 n_rst = 1'b0;
        #1;
        check("arst_out_valid", {31'b0, out_if.valid}, 32'd0);
        check("arst_active_mode", {30'b0, active_mode}, 32'd0);
        exp_q.delete();
        m_mode  = 2'b00;
        m_coeff = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1 out_if.ready = 1'b1;
        repeat (5) @(negedge clk);
        check("postrst_no_stale", {31'b0, out_if.valid}, 32'd0);
        @(posedge clk);
        #1 filter_mode = 2'b11;
        send(32'h1234_5678, 1'b0, 32'h1234_5678);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
